// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: shifts 24-bit pixel words MSB first as timed pulses, ends frames
// with a latch low period. Define WS2812_TX_STATS_EN to add frame_count and underrun outputs.
module ws2812_tx #(
   parameter int unsigned T0H_CYC   = 40,
   parameter int unsigned T1H_CYC   = 80,
   parameter int unsigned TBIT_CYC  = 125,
   parameter int unsigned LATCH_CYC = 6000
) (
   input  logic        clk_100,
   input  logic        glbl_reset,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        latch_req,
   output logic        led_sdi,
`ifdef WS2812_TX_STATS_EN
   output logic [15:0] frame_count,
   output logic        underrun,
`endif
   output logic        busy
);

   localparam int unsigned CW = $clog2(LATCH_CYC + 1);
   localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYC - 1);
   localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYC - 1);
   localparam logic [CW-1:0] TBIT_LAST  = CW'(TBIT_CYC - 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
   localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

   typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [23:0]   r_sr, w_sr_nxt;
   logic [4:0]    r_bit, w_bit_nxt;
   logic          r_pend, w_pend_nxt;
   logic          r_sdi;
   logic          r_rdy_en;
   logic          w_ready;
   logic [CW-1:0] w_hi_last;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
      w_sr_nxt    = r_sr;
      w_bit_nxt   = r_bit;
      w_pend_nxt  = r_pend;
      w_ready     = 1'b0;
      w_hi_last   = r_sr[23] ? T1H_LAST : T0H_LAST;
      unique case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            w_ready   = r_rdy_en & ~latch_req;
            if (latch_req) begin
               w_state_nxt = StLatch;
            end else if (pix_valid && w_ready) begin
               w_sr_nxt    = pix_data;
               w_bit_nxt   = '0;
               w_state_nxt = StHigh;
            end
         end
         StHigh: begin
            if (latch_req) w_pend_nxt = 1'b1;
            if (r_cnt == w_hi_last) w_state_nxt = StLow;
         end
         StLow: begin
            if (latch_req) w_pend_nxt = 1'b1;
            if (r_cnt == TBIT_LAST) begin
               w_cnt_nxt = '0;
               if (r_bit != 5'd23) begin
                  w_sr_nxt    = {r_sr[22:0], 1'b0};
                  w_bit_nxt   = r_bit + 5'd1;
                  w_state_nxt = StHigh;
               end else if (r_pend || latch_req) begin
                  // a pending latch wins over any waiting word
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = StLatch;
               end else begin
                  w_ready = 1'b1;
                  if (pix_valid) begin
                     w_sr_nxt    = pix_data;
                     w_bit_nxt   = '0;
                     w_state_nxt = StHigh;
                  end else begin
                     w_state_nxt = StLatch;
                  end
               end
            end
         end
         StLatch: begin
            if (r_cnt == LATCH_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_100) begin
      if (glbl_reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_sr     <= '0;
         r_bit    <= '0;
         r_pend   <= 1'b0;
         r_sdi    <= 1'b0;
         r_rdy_en <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_sr     <= w_sr_nxt;
         r_bit    <= w_bit_nxt;
         r_pend   <= w_pend_nxt;
         r_sdi    <= (w_state_nxt == StHigh);
         r_rdy_en <= 1'b1;
      end
   end

`ifdef WS2812_TX_STATS_EN
   logic [15:0] r_frame_count;
   logic        r_underrun;

   always_ff @(posedge clk_100) begin
      if (glbl_reset) begin
         r_frame_count <= '0;
         r_underrun    <= 1'b0;
      end else if (w_state_nxt == StLatch && r_state != StLatch) begin
         r_frame_count <= r_frame_count + 16'd1;
         // only the no-word, no-request exit from the last bit counts as underrun
         if (r_state == StLow && !r_pend && !latch_req) r_underrun <= 1'b1;
      end
   end

   assign frame_count = r_frame_count;
   assign underrun    = r_underrun;
`endif

   assign pix_ready = w_ready;
   assign led_sdi   = r_sdi;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_ws2812_tx.sv
// Self-checking bench for ws2812_tx: timeline model, pulse-width receiver and directed literals.
module tb_ws2812_tx;

   localparam int T0H   = 40;
   localparam int T1H   = 80;
   localparam int TBIT  = 125;
   localparam int LATCH = 6000;
   localparam int WORD  = 24 * TBIT;

   logic        clk_100 = 1'b0;
   logic        glbl_reset = 1'b1;
   logic [23:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        latch_req = 1'b0;
   logic        pix_ready, led_sdi, busy;
`ifdef WS2812_TX_STATS_EN
   logic [15:0] frame_count;
   logic        underrun;
`endif

   ws2812_tx #(
      .T0H_CYC  (T0H),
      .T1H_CYC  (T1H),
      .TBIT_CYC (TBIT),
      .LATCH_CYC(LATCH)
   ) dut (
      .clk_100    (clk_100),
      .glbl_reset (glbl_reset),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .latch_req  (latch_req),
      .led_sdi    (led_sdi),
`ifdef WS2812_TX_STATS_EN
      .frame_count(frame_count),
      .underrun   (underrun),
`endif
      .busy       (busy)
   );

   always #5 clk_100 = ~clk_100;

   int unsigned cyc = 0;
   always @(posedge clk_100) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Timeline model: mode 0 idle, 1 word (t = clocks since word start), 2 latch
   bit          m_on = 1'b0;
   int          m_mode = 0;
   int          m_t = 0;
   logic [23:0] m_word = '0;
   bit          m_pend = 1'b0;
   bit          m_rdy_en = 1'b0;
   logic [15:0] m_frames = '0;
   bit          m_under = 1'b0;
   bit          m_acc;
   logic [23:0] exp_q[$];

   function automatic bit m_ready();
      return m_rdy_en && !latch_req &&
             (m_mode == 0 || (m_mode == 1 && m_t == WORD - 1 && !m_pend));
   endfunction

   function automatic bit m_sdi();
      int bitk, ph;
      if (m_mode != 1) return 1'b0;
      bitk = m_t / TBIT;
      ph   = m_t % TBIT;
      return ph < (m_word[23 - bitk] ? T1H : T0H);
   endfunction

   always @(posedge clk_100) begin
      if (glbl_reset) begin
         if (m_on && m_mode == 1 && exp_q.size() > 0) void'(exp_q.pop_back());
         m_on = 1'b1; m_mode = 0; m_t = 0; m_pend = 1'b0; m_rdy_en = 1'b0;
         m_frames = '0; m_under = 1'b0;
      end else if (m_on) begin
         m_acc = pix_valid && m_ready();
         m_rdy_en = 1'b1;
         case (m_mode)
            0: begin
               if (latch_req) begin
                  m_mode = 2; m_t = 0; m_frames++;
               end else if (m_acc) begin
                  m_mode = 1; m_t = 0; m_word = pix_data; exp_q.push_back(pix_data);
               end
            end
            1: begin
               if (latch_req) m_pend = 1'b1;
               if (m_t == WORD - 1) begin
                  m_t = 0;
                  if (m_pend) begin
                     m_mode = 2; m_pend = 1'b0; m_frames++;
                  end else if (m_acc) begin
                     m_word = pix_data; exp_q.push_back(pix_data);
                  end else begin
                     m_mode = 2; m_under = 1'b1; m_frames++;
                  end
               end else begin
                  m_t++;
               end
            end
            default: begin
               if (m_t == LATCH - 1) begin
                  m_mode = 0; m_t = 0;
               end else begin
                  m_t++;
               end
            end
         endcase
      end
   end

   always @(negedge clk_100) begin
      if (m_on) begin
         chk("led_sdi", led_sdi, m_sdi());
         chk("busy", busy, m_mode != 0);
         chk("pix_ready", pix_ready, m_ready());
`ifdef WS2812_TX_STATS_EN
         chk("frame_count", frame_count, m_frames);
         chk("underrun", underrun, m_under);
`endif
      end
   end

   // Receiver: classifies pulses by measured ns windows and rebuilds pixels
   bit          rx_prev = 1'b0, rx_last = 1'b0, rx_low_open = 1'b0, rx_ok0, rx_ok1;
   int          rx_hi = 0, rx_lo = 0, rx_nb = 0, rx_pix = 0;
   logic [23:0] rx_sr = '0, rx_exp;

   function automatic bit low_ok(input bit b, input int ns);
      return b ? (ns >= 300 && ns <= 600) : (ns >= 700 && ns <= 1000);
   endfunction

   always @(negedge clk_100) begin
      if (glbl_reset) begin
         rx_prev = 1'b0; rx_hi = 0; rx_lo = 0; rx_low_open = 1'b0; rx_nb = 0;
      end else if (led_sdi) begin
         if (!rx_prev) begin
            if (rx_low_open) chk("rx_low_window", low_ok(rx_last, rx_lo * 10), 1);
            rx_low_open = 1'b0;
            rx_hi = 0;
         end
         rx_hi++;
         rx_prev = 1'b1;
      end else begin
         if (rx_prev) begin
            rx_ok0 = (rx_hi * 10 >= 250) && (rx_hi * 10 <= 550);
            rx_ok1 = (rx_hi * 10 >= 650) && (rx_hi * 10 <= 950);
            chk("rx_high_window", rx_ok0 || rx_ok1, 1);
            rx_last = rx_ok1;
            rx_sr = {rx_sr[22:0], rx_ok1};
            rx_nb++;
            if (rx_nb == 24) begin
               rx_nb = 0;
               rx_pix++;
               rx_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
               chk("rx_pixel", rx_sr, rx_exp);
            end
            rx_lo = 0;
            rx_low_open = 1'b1;
         end
         rx_lo++;
         if (rx_low_open && rx_lo * 10 > 1000) begin
            rx_low_open = 1'b0;
            chk("rx_frame_boundary", rx_nb, 0);
         end
         rx_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_100);
      #1;
   endtask

   // Leaves pix_valid high; returns 1 time unit after the accepting edge.
   task automatic send_word(input logic [23:0] w);
      int n = 0;
      pix_data  = w;
      pix_valid = 1'b1;
      #1;
      while (!pix_ready && n < 10000) begin
         @(posedge clk_100);
         #2;
         n++;
      end
      chk("send_wait_bound", n < 10000, 1);
      step();
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         step();
         n++;
      end
      chk("idle_wait_bound", n < max, 1);
   endtask

   initial begin
      int unsigned c0;
      int          n;
      logic [31:0] rw;

      repeat (3) step();
      chk("rst_sdi", led_sdi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", pix_ready, 0);
      glbl_reset = 1'b0;
      #1;
      chk("ready_before_first_clk", pix_ready, 0);
      step();
      chk("ready_after_release", pix_ready, 1);

      // all-ones word, then underrun into latch
      send_word(24'hFFFFFF);
      c0 = cyc;
      pix_valid = 1'b0;
      n = 0;
      while (led_sdi && n < 200) begin step(); n++; end
      chk("t1h_cycles", n, 80);
      n = 0;
      while (!led_sdi && n < 200) begin step(); n++; end
      chk("t1l_cycles", n, 45);
      wait_idle(20000);
      chk("word_plus_latch_cycles", cyc - c0, 9000);
`ifdef WS2812_TX_STATS_EN
      chk("frames_after_underrun", frame_count, 1);
      chk("underrun_sticky", underrun, 1);
`endif
      step();

      // back-to-back words, latch request during bit 5 of the third
      send_word(24'h000000);
      send_word(24'hA5C30F);
      send_word(24'h123456);
      c0 = cyc;
      pix_data = 24'h654321;
      repeat (5 * TBIT + 10) step();
      latch_req = 1'b1;
      step();
      latch_req = 1'b0;
      send_word(24'h654321);
      chk("latch_gap_cycles", cyc - c0, 9001);
`ifdef WS2812_TX_STATS_EN
      chk("frames_after_req", frame_count, 2);
`endif

      // reset during HIGH of bit 10
      pix_valid = 1'b0;
      repeat (10 * TBIT + 5) step();
      chk("sdi_before_reset", led_sdi, 1);
      glbl_reset = 1'b1;
      step();
      chk("rst_mid_bit_sdi", led_sdi, 0);
      chk("rst_mid_bit_busy", busy, 0);
      step();
      glbl_reset = 1'b0;
      step();

      send_word(24'h800001);
      for (int i = 0; i < 16; i++) begin
         rw = $urandom;
         send_word(rw[23:0]);
      end
      pix_valid = 1'b0;
      repeat (100) step();
      latch_req = 1'b1;
      step();
      latch_req = 1'b0;
      wait_idle(10000);
      repeat (5) step();
      chk("rx_pixels", rx_pix, 21);
      chk("exp_queue_empty", exp_q.size(), 0);
`ifdef WS2812_TX_STATS_EN
      chk("frames_final", frame_count, 1);
      chk("underrun_final", underrun, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      repeat (95000) @(posedge clk_100);
      $display("FAIL watchdog: cycle budget exhausted, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 SHALL have parameter T0H_CYC, default 40, meaning high time of a 0 bit in clocks (400 ns at 100 MHz).
REQ-002 SHALL have parameter T1H_CYC, default 80, meaning high time of a 1 bit in clocks (800 ns).
REQ-003 SHALL have parameter TBIT_CYC, default 125, meaning total bit period in clocks (1.25 us); T0L = TBIT_CYC-T0H_CYC, T1L = TBIT_CYC-T1H_CYC.
REQ-004 SHALL have parameter LATCH_CYC, default 6000, meaning minimum low time that ends a frame (60 us).
REQ-005 SHALL have port clk_100, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port glbl_reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pix_data, input, 24 bits: pixel word, sent MSB first.
REQ-008 SHALL have port pix_valid, input, 1 bit: pix_data is valid.
REQ-009 SHALL have port pix_ready, output, 1 bit: a word is accepted when pix_valid and pix_ready are both high on a clock edge.
REQ-010 SHALL have port latch_req, input, 1 bit: single-cycle request to end the current frame.
REQ-011 SHALL have port led_sdi, output, 1 bit: serial line to the LED string.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW and LATCH.
REQ-014 pix_ready SHALL be high only in IDLE, and in the last clock of LOW for bit 0 of the current word.
REQ-015 In IDLE, an accepted word SHALL be loaded into a 24-bit shift register and the block SHALL enter HIGH on the next clock.
REQ-016 In HIGH, led_sdi SHALL be 1 for exactly T1H_CYC clocks if the current MSB is 1, else T0H_CYC clocks, and the block SHALL then enter LOW.
REQ-017 In LOW, led_sdi SHALL be 0 until TBIT_CYC clocks have elapsed since that bit's HIGH started.
REQ-018 At the end of LOW, if bits remain, the block SHALL shift left by one and enter HIGH with no gap clock.
REQ-019 At the end of LOW for the last bit, an accepted next word SHALL start HIGH on the next clock, giving a gapless bit stream.
REQ-020 At the end of LOW for the last bit with no word accepted (underrun), the block SHALL enter LATCH.
REQ-021 latch_req in IDLE SHALL enter LATCH; latch_req in HIGH or LOW SHALL be held pending and SHALL take effect after the current word, with priority over a valid next word.
REQ-022 In LATCH, led_sdi SHALL be 0 for exactly LATCH_CYC clocks, pix_ready SHALL be 0, and the block SHALL then return to IDLE.
REQ-023 latch_req during LATCH SHALL be ignored and SHALL NOT restart the count.
REQ-024 The bit-time counter SHALL be sized as $clog2(LATCH_CYC+1) bits, SHALL be shared by all states, and SHALL NOT wrap.
REQ-025 led_sdi SHALL be registered and glitch-free.

Reset
REQ-026 On glbl_reset, state SHALL be IDLE, led_sdi=0, busy=0, pix_ready=0, the shift register, counters and pending latch flag SHALL be cleared, and pix_ready SHALL return to 1 on the first clock after reset deasserts.
REQ-027 glbl_reset asserted mid-bit SHALL drive led_sdi to 0 on the next edge, abandoning the word and leaving no partial bit.

Configuration
REQ-028 Macro WS2812_TX_STATS_EN: when defined, the block SHALL add outputs frame_count[15:0] (increments on each LATCH entry, wraps at 0xFFFF) and underrun[0] (sticky, set when LATCH is entered via REQ-020 rather than latch_req, cleared by reset); when undefined, these ports and registers SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then send word 0xFFFFFF -> 24 pulses of 800 ns high / 450 ns low; busy=1 throughout.
REQ-030 Send 0x000000 then 0xA5C30F back-to-back -> 48 bits, 400/850 ns for 0 and 800/450 ns for 1, no gap between words, decoded values match.
REQ-031 Send one word, then hold pix_valid low -> LATCH entered, led_sdi low for exactly 60 us, then IDLE; with WS2812_TX_STATS_EN, frame_count=1 and underrun=1.
REQ-032 Pulse latch_req during bit 5 of word 0x123456 with next word valid -> word completes, 60 us low, then next word starts; underrun=0.
REQ-033 Assert glbl_reset during HIGH of bit 10 -> led_sdi=0 the next clock; after release, a new word 0x800001 is transmitted correctly.
REQ-034 Drive 16 random words (two strings of 8), then latch_req -> a receiver model using 250-550/700-1000 ns 0-bit and 650-950/300-600 ns 1-bit windows reports a match on every pixel.
